// File: rtl/lfsr_seq_ctrl.sv
// Start/step/done sequencer around a Fibonacci LFSR and its step counter.
// Build with LFSR_WRAP_DET_EN defined to add the sticky period-wrap detector.
module lfsr_seq_ctrl #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1001,
  parameter int unsigned      CNT_W = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] n_steps,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             step_v,
  output logic             done,
  output logic             err,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Feedback is the parity of the tapped bits, shifted in at the LSB.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], ^(v & TAPS)};
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             step_s;
  logic             err_s;
  logic             busy_r;
  logic             step_v_r;
  logic             done_r;
  logic             err_r;

  // Next-state, shift-register and counter update for the sequencer FSM.
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    cnt_s   = cnt_r;
    step_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (seed != {WIDTH{1'b0}}) begin
            q_s   = seed;
            cnt_s = n_steps;
            if (n_steps != {CNT_W{1'b0}}) begin
              state_s = ST_RUN;
            end else begin
              state_s = ST_DONE;
            end
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (en) begin
          q_s    = lfsr_next(q_r);
          cnt_s  = cnt_r - CNT_W'(1);
          step_s = 1'b1;
          if (cnt_r == CNT_W'(1)) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and flag registers; flags are derived from the next state.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      q_r      <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      step_v_r <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      q_r      <= q_s;
      cnt_r    <= cnt_s;
      busy_r   <= (state_s == ST_RUN);
      step_v_r <= step_s;
      done_r   <= (state_s == ST_DONE);
      err_r    <= err_s;
    end
  end

`ifdef LFSR_WRAP_DET_EN
  logic             accept_s;
  logic [WIDTH-1:0] seed_copy_r;
  logic             wrap_r;

  assign accept_s = (state_r == ST_IDLE) && start && (seed != {WIDTH{1'b0}});

  // Sticky flag: a step returned the register to the seed of the current run.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      seed_copy_r <= {WIDTH{1'b0}};
      wrap_r      <= 1'b0;
    end else if (accept_s) begin
      seed_copy_r <= seed;
      wrap_r      <= 1'b0;
    end else if (step_s && (q_s == seed_copy_r)) begin
      wrap_r      <= 1'b1;
    end
  end

  assign wrap = wrap_r;
`else
  assign wrap = 1'b0;
`endif

  assign q      = q_r;
  assign busy   = busy_r;
  assign step_v = step_v_r;
  assign done   = done_r;
  assign err    = err_r;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench for lfsr_seq_ctrl: the driver predicts every step/done/err
// pulse from a sequence-level model, a negedge monitor pops and compares.
module tb_lfsr_seq_ctrl;

  localparam logic [3:0] TAPS = 4'b1001;
`ifdef LFSR_WRAP_DET_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  localparam int EV_STEP = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int         kind;
    logic [3:0] q;
    logic       wrap;
    logic       busy;
  } ev_t;

  logic       clock = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] seed;
  logic [7:0] n_steps;
  logic       en;
  logic       abort;
  logic [3:0] q;
  logic       busy;
  logic       step_v;
  logic       done;
  logic       err;
  logic       wrap;

  int  checks = 0;
  int  errors = 0;
  ev_t sb[$];

  logic [3:0] model_q    = 4'd0;
  logic       model_wrap = 1'b0;

  lfsr_seq_ctrl #(.WIDTH(4), .TAPS(TAPS), .CNT_W(8)) dut (
    .clock   (clock),
    .rst     (rst),
    .start   (start),
    .seed    (seed),
    .n_steps (n_steps),
    .en      (en),
    .abort   (abort),
    .q       (q),
    .busy    (busy),
    .step_v  (step_v),
    .done    (done),
    .err     (err),
    .wrap    (wrap)
  );

  always #5 clock = ~clock;

  // Reference step: new LSB is the odd/even count of tapped ones, old bits move up.
  function automatic logic [3:0] ref_step(input logic [3:0] v);
    int fb;
    fb = $countones(v & TAPS) % 2;
    return 4'((int'(v) * 2 + fb) % 16);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic pop_cmp(input int kind);
    ev_t e;
    string names[3];
    names[0] = "step";
    names[1] = "done";
    names[2] = "err";
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s got pulse expected none at %0t", names[kind], $time);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.q !== q || e.wrap !== wrap || e.busy !== busy) begin
        errors++;
        $display("FAIL ev_%s got kind=%s q=%b wrap=%b busy=%b expected kind=%s q=%b wrap=%b busy=%b at %0t",
                 names[kind], names[kind], q, wrap, busy, names[e.kind], e.q, e.wrap, e.busy, $time);
      end
    end
  endtask

  // Monitor: every output pulse must match the next predicted event.
  always @(negedge clock) begin
    if (!rst) begin
      if (step_v) pop_cmp(EV_STEP);
      if (done)   pop_cmp(EV_DONE);
      if (err)    pop_cmp(EV_ERR);
    end
  end

  // mode: 0 en always 1, 1 random en, 2 en from pat (LSB first)
  // stop_kind: 0 run to done, 1 abort after stop_at steps, 2 rst after stop_at steps
  task automatic run(input logic [3:0] s, input int n, input int mode,
                     input logic [15:0] pat, input int stop_at, input int stop_kind);
    ev_t        e;
    logic [3:0] qq;
    int         lim;
    int         steps;
    int         cyc;
    lim = (stop_kind != 0) ? stop_at : n;
    model_wrap = 1'b0;
    qq = s;
    for (int j = 1; j <= lim; j++) begin
      qq = ref_step(qq);
      if (qq == s) model_wrap = WRAP_ON;
      e = '{EV_STEP, qq, model_wrap, (j != n)};
      sb.push_back(e);
    end
    if (stop_kind == 0) begin
      e = '{EV_DONE, qq, model_wrap, 1'b0};
      sb.push_back(e);
    end

    seed = s;
    n_steps = 8'(n);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(n != 0));
    chk("q_after_start", 32'(q), 32'(s));

    steps = 0;
    cyc = 0;
    while (n != 0 && steps < n) begin
      if (stop_kind == 1 && steps == stop_at) begin
        abort = 1'b1;
        en = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        en = 1'b0;
        chk("busy_after_abort", 32'(busy), 32'd0);
        chk("q_after_abort", 32'(q), 32'(qq));
        break;
      end
      if (stop_kind == 2 && steps == stop_at) begin
        en = 1'b0;
        @(negedge clock); #1;
        rst = 1'b1;
        #1;
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_flags", 32'({busy, step_v, done, err, wrap}), 32'd0);
        @(posedge clock); #1;
        rst = 1'b0;
        break;
      end
      case (mode)
        0:       en = 1'b1;
        2:       en = (cyc < 16) ? pat[cyc] : 1'b1;
        default: en = ($urandom_range(0, 9) < 7);
      endcase
      start = ($urandom_range(0, 3) == 0);
      seed = 4'($urandom);
      @(posedge clock); #1;
      start = 1'b0;
      if (en) steps++;
      cyc++;
      if (cyc > 500) begin
        checks++;
        errors++;
        $display("FAIL run_timeout got %0d steps expected %0d", steps, n);
        break;
      end
    end
    en = 1'b0;
    if (stop_kind == 2) begin
      model_q = 4'd0;
      model_wrap = 1'b0;
    end else begin
      model_q = qq;
      @(posedge clock); #1;
      chk("busy_idle", 32'(busy), 32'd0);
      chk("done_idle", 32'(done), 32'd0);
    end
  endtask

  task automatic do_err();
    ev_t e;
    seed = 4'd0;
    n_steps = 8'($urandom_range(0, 255));
    start = 1'b1;
    e = '{EV_ERR, model_q, model_wrap, 1'b0};
    sb.push_back(e);
    @(posedge clock); #1;
    start = 1'b0;
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_q", 32'(q), 32'(model_q));
    @(posedge clock); #1;
    chk("err_one_cycle", 32'(err), 32'd0);
  endtask

  initial begin
    int n;
    int sk;
    int sa;
    rst = 1'b1;
    start = 1'b0;
    en = 1'b0;
    abort = 1'b0;
    seed = 4'd0;
    n_steps = 8'd0;
    #2;
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_flags", 32'({busy, step_v, done, err, wrap}), 32'd0);
    @(posedge clock);
    @(posedge clock); #1;
    rst = 1'b0;

    run(4'b0001, 3, 0, 16'd0, 0, 0);
    chk("q_final_3", 32'(q), 32'(4'b1111));
    run(4'b0001, 15, 0, 16'd0, 0, 0);
    chk("q_final_15", 32'(q), 32'(4'b0001));
    chk("wrap_after_period", 32'(wrap), 32'(WRAP_ON));
    do_err();
    run(4'b0001, 0, 0, 16'd0, 0, 0);
    chk("wrap_cleared", 32'(wrap), 32'd0);
    run(4'b0001, 4, 2, 16'b0000_0000_0101_1001, 0, 0);
    chk("q_final_pattern", 32'(q), 32'(4'b1110));
    run(4'b0001, 10, 0, 16'd0, 2, 1);
    chk("q_abort_hold", 32'(q), 32'(4'b0111));
    run(4'b0001, 10, 0, 16'd0, 2, 2);
    chk("q_after_rst", 32'(q), 32'd0);

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 4) == 0) do_err();
      n = $urandom_range(0, 20);
      sk = (n == 0) ? 0 : $urandom_range(0, 2);
      if (sk == 2 && $urandom_range(0, 1) == 0) sk = 0;
      sa = (n == 0) ? 0 : $urandom_range(0, n - 1);
      run(4'($urandom_range(1, 15)), n, 1, 16'd0, sa, sk);
    end

    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
